// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the core's data-memory port.
// Accepts one load/store at a time over a valid/ready request channel, performs it on an
// internal word array after LATENCY cycles and returns extended load data on a valid/ready
// response channel.
//
// Parameters:
//   BASE_ADDR    byte address mapped to array word 0
//   DEPTH_WORDS  number of 32-bit words in the array (power of two, >= 2)
//   LATENCY      cycles from request accept to rsp_valid (1..15)
//
// Ports:
//   clock, reset                rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready         request handshake (ready only while idle)
//   req_write                   1 = store, 0 = load
//   req_addr, req_funct3        byte address, RV32I access size/sign encoding
//   req_wdata                   right-aligned store data
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata, rsp_err          extended load data (0 for stores/errors), rejection flag
//
// Configuration macro: DMEM_MISALIGN_TRAP_EN
//   defined   -> misaligned halfword/word accesses are rejected with rsp_err
//   undefined -> low address bits are masked for halfword/word accesses
module dmem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        cap_write;
   logic [31:0] cap_addr;
   logic [2:0]  cap_funct3;
   logic [31:0] cap_wdata;

   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0]      offset;
   logic [IDX_W-1:0] idx;
   logic [31:0]      rd_word;
   logic [7:0]       byte_sel;
   logic [15:0]      half_sel;
   logic [31:0]      ld_data;
   logic [31:0]      st_word;
   logic             legal;
   logic             access_ok;
   logic             fire;
   logic             mem_we;

   assign req_ready = (state == StIdle) && !reset;

   always_comb begin
      // Out-of-range addresses simply wrap onto the array.
      offset   = cap_addr - BASE_ADDR;
      idx      = IDX_W'(offset >> 2);
      rd_word  = mem[idx];

      if (cap_write) begin
         legal = (cap_funct3 == 3'b000) || (cap_funct3 == 3'b001) || (cap_funct3 == 3'b010);
      end else begin
         legal = (cap_funct3 == 3'b000) || (cap_funct3 == 3'b001) || (cap_funct3 == 3'b010) ||
                 (cap_funct3 == 3'b100) || (cap_funct3 == 3'b101);
      end

`ifdef DMEM_MISALIGN_TRAP_EN
      access_ok = legal &&
                  !((cap_funct3[1:0] == 2'b01) && cap_addr[0]) &&
                  !((cap_funct3[1:0] == 2'b10) && (cap_addr[1:0] != 2'b00));
`else
      access_ok = legal;
`endif

      case (cap_addr[1:0])
         2'b00:   byte_sel = rd_word[7:0];
         2'b01:   byte_sel = rd_word[15:8];
         2'b10:   byte_sel = rd_word[23:16];
         default: byte_sel = rd_word[31:24];
      endcase
      half_sel = cap_addr[1] ? rd_word[31:16] : rd_word[15:0];

      case (cap_funct3)
         3'b000:  ld_data = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  ld_data = {{16{half_sel[15]}}, half_sel};
         3'b010:  ld_data = rd_word;
         3'b100:  ld_data = {24'd0, byte_sel};
         3'b101:  ld_data = {16'd0, half_sel};
         default: ld_data = 32'd0;
      endcase

      // Read-modify-write merge so that untouched lanes keep their contents.
      st_word = rd_word;
      case (cap_funct3[1:0])
         2'b00: begin
            case (cap_addr[1:0])
               2'b00:   st_word[7:0]   = cap_wdata[7:0];
               2'b01:   st_word[15:8]  = cap_wdata[7:0];
               2'b10:   st_word[23:16] = cap_wdata[7:0];
               default: st_word[31:24] = cap_wdata[7:0];
            endcase
         end
         2'b01: begin
            if (cap_addr[1]) st_word[31:16] = cap_wdata[15:0];
            else             st_word[15:0]  = cap_wdata[15:0];
         end
         2'b10:   st_word = cap_wdata;
         default: st_word = rd_word;
      endcase

      // The access happens on the edge that leaves BUSY; reset holds state in IDLE, so a
      // store pending when reset hits is never written.
      fire   = (state == StBusy) && (cnt == 4'd0);
      mem_we = fire && cap_write && access_ok;
   end

   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[idx] <= st_word;
      end
   end

   // cnt holds the number of BUSY cycles still to wait before the access edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= StIdle;
         cnt        <= 4'd0;
         cap_write  <= 1'b0;
         cap_addr   <= 32'd0;
         cap_funct3 <= 3'd0;
         cap_wdata  <= 32'd0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= 32'd0;
         rsp_err    <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (req_valid) begin
                  cap_write  <= req_write;
                  cap_addr   <= req_addr;
                  cap_funct3 <= req_funct3;
                  cap_wdata  <= req_wdata;
                  cnt        <= CNT_INIT;
                  state      <= StBusy;
               end
            end
            StBusy: begin
               if (cnt == 4'd0) begin
                  state     <= StResp;
                  rsp_valid <= 1'b1;
                  rsp_err   <= !access_ok;
                  rsp_rdata <= (access_ok && !cap_write) ? ld_data : 32'd0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            StResp: begin
               if (rsp_ready) begin
                  state     <= StIdle;
                  rsp_valid <= 1'b0;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: table-driven directed vectors, hand-written multi-cycle
// sequences and randomized traffic checked against a byte-level reference model.
// Two instances: A with LATENCY=2, B with LATENCY=4; a select routes the shared stimulus.
module tb_dmem_responder;

   localparam logic [31:0] BASE      = 32'h0100_0000;
   localparam int unsigned MEM_BYTES = 4096;

   logic clock;
   logic reset_a, reset_b;
   logic sel;

   logic        req_valid, req_write, rsp_ready;
   logic [31:0] req_addr, req_wdata;
   logic [2:0]  req_funct3;

   logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
   logic [31:0] a_rsp_rdata;
   logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
   logic [31:0] b_rsp_rdata;

   logic        o_req_ready, o_rsp_valid, o_rsp_err;
   logic [31:0] o_rsp_rdata;

   assign a_req_valid = req_valid & ~sel;
   assign b_req_valid = req_valid & sel;
   assign a_rsp_ready = rsp_ready & ~sel;
   assign b_rsp_ready = rsp_ready & sel;
   assign o_req_ready = sel ? b_req_ready : a_req_ready;
   assign o_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
   assign o_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
   assign o_rsp_err   = sel ? b_rsp_err   : a_rsp_err;

   dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .LATENCY(2)) u_dut_a (
      .clock      (clock),
      .reset      (reset_a),
      .req_valid  (a_req_valid),
      .req_ready  (a_req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_funct3 (req_funct3),
      .req_wdata  (req_wdata),
      .rsp_valid  (a_rsp_valid),
      .rsp_ready  (a_rsp_ready),
      .rsp_rdata  (a_rsp_rdata),
      .rsp_err    (a_rsp_err)
   );

   dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .LATENCY(4)) u_dut_b (
      .clock      (clock),
      .reset      (reset_b),
      .req_valid  (b_req_valid),
      .req_ready  (b_req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_funct3 (req_funct3),
      .req_wdata  (req_wdata),
      .rsp_valid  (b_rsp_valid),
      .rsp_ready  (b_rsp_ready),
      .rsp_rdata  (b_rsp_rdata),
      .rsp_err    (b_rsp_err)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int vectors;
   int miscompares;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: byte-addressed image of instance A's array.
   logic [7:0] mb [MEM_BYTES];

   function automatic void model_op(input logic w, input logic [31:0] a, input logic [2:0] f3,
                                    input logic [31:0] wd, output logic [31:0] rd,
                                    output logic er);
      int unsigned off, size;
      logic ok;
      logic [31:0] v;
      off  = (a - BASE) % MEM_BYTES;
      size = 1 << f3[1:0];
      ok   = w ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
`ifdef DMEM_MISALIGN_TRAP_EN
      if ((off % size) != 0) ok = 1'b0;
`endif
      rd = 32'd0;
      er = !ok;
      if (!ok) return;
      off = off - (off % size);
      if (w) begin
         for (int i = 0; i < int'(size); i++) mb[(off + i) % MEM_BYTES] = wd[8*i +: 8];
      end else begin
         v = 32'd0;
         for (int i = 0; i < int'(size); i++) v = v | (32'(mb[(off + i) % MEM_BYTES]) << (8*i));
         if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
         rd = v;
      end
   endfunction

   // Full transaction; called and returning at #1 after a rising edge.
   task automatic txn(input logic w, input logic [31:0] a, input logic [2:0] f3,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er);
      int n;
      int lat;
      req_write  = w;
      req_addr   = a;
      req_funct3 = f3;
      req_wdata  = wd;
      req_valid  = 1'b1;
      n = 0;
      while (!o_req_ready && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      check("req_ready_wait", 32'(n < 50), 32'd1);
      @(posedge clock); #1;
      req_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clock); #1;
         lat++;
      end while (!o_rsp_valid && lat < 50);
      check("latency", 32'(lat), sel ? 32'd4 : 32'd2);
      rd = o_rsp_rdata;
      er = o_rsp_err;
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
      check("rsp_valid_drop", 32'(o_rsp_valid), 32'd0);
   endtask

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [2:0]  f3;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_er;
   } vec_t;

   localparam int NV = 23;
   vec_t tv [NV];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, mrd;
      logic        er, mer;
      int          lat;
      int          n;

      vectors = 0;
      miscompares = 0;

      tv[0]  = '{1'b1, 32'h0100_0010, 3'd2, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
      tv[1]  = '{1'b0, 32'h0100_0010, 3'd2, 32'h0,         32'hDEAD_BEEF, 1'b0};
      tv[2]  = '{1'b1, 32'h0100_0020, 3'd2, 32'h80FF_7F01, 32'h0000_0000, 1'b0};
      tv[3]  = '{1'b0, 32'h0100_0023, 3'd0, 32'h0,         32'hFFFF_FF80, 1'b0};
      tv[4]  = '{1'b0, 32'h0100_0023, 3'd4, 32'h0,         32'h0000_0080, 1'b0};
      tv[5]  = '{1'b0, 32'h0100_0022, 3'd1, 32'h0,         32'hFFFF_80FF, 1'b0};
      tv[6]  = '{1'b0, 32'h0100_0020, 3'd5, 32'h0,         32'h0000_7F01, 1'b0};
      tv[7]  = '{1'b1, 32'h0100_0040, 3'd2, 32'h1122_3344, 32'h0000_0000, 1'b0};
      tv[8]  = '{1'b1, 32'h0100_0041, 3'd0, 32'h0000_00AA, 32'h0000_0000, 1'b0};
      tv[9]  = '{1'b0, 32'h0100_0040, 3'd2, 32'h0,         32'h1122_AA44, 1'b0};
      tv[10] = '{1'b1, 32'h0100_0042, 3'd1, 32'h0000_BBCC, 32'h0000_0000, 1'b0};
      tv[11] = '{1'b0, 32'h0100_0040, 3'd2, 32'h0,         32'hBBCC_AA44, 1'b0};
      tv[12] = '{1'b1, 32'h0100_0000, 3'd2, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
      tv[13] = '{1'b0, 32'h0100_0002, 3'd2, 32'h0,         32'h0000_0000, 1'b1};
`else
      tv[13] = '{1'b0, 32'h0100_0002, 3'd2, 32'h0,         32'hCAFE_F00D, 1'b0};
`endif
      tv[14] = '{1'b0, 32'h0100_0000, 3'd3, 32'h0,         32'h0000_0000, 1'b1};
      tv[15] = '{1'b1, 32'h0100_0000, 3'd3, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
      tv[16] = '{1'b1, 32'h0100_0000, 3'd4, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
`ifdef DMEM_MISALIGN_TRAP_EN
      tv[17] = '{1'b1, 32'h0100_0002, 3'd2, 32'h0000_0055, 32'h0000_0000, 1'b1};
      tv[18] = '{1'b0, 32'h0100_1000, 3'd2, 32'h0,         32'hCAFE_F00D, 1'b0};
      tv[19] = '{1'b0, 32'h0100_0021, 3'd1, 32'h0,         32'h0000_0000, 1'b1};
`else
      tv[17] = '{1'b1, 32'h0100_0002, 3'd2, 32'h0000_0055, 32'h0000_0000, 1'b0};
      tv[18] = '{1'b0, 32'h0100_1000, 3'd2, 32'h0,         32'h0000_0055, 1'b0};
      tv[19] = '{1'b0, 32'h0100_0021, 3'd1, 32'h0,         32'h0000_7F01, 1'b0};
`endif
      tv[20] = '{1'b0, 32'h0100_0013, 3'd0, 32'h0,         32'hFFFF_FFDE, 1'b0};
      tv[21] = '{1'b0, 32'h0100_0012, 3'd5, 32'h0,         32'h0000_DEAD, 1'b0};
      tv[22] = '{1'b0, 32'h0100_0010, 3'd6, 32'h0,         32'h0000_0000, 1'b1};

      sel = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr = 32'd0;
      req_funct3 = 3'd0;
      req_wdata = 32'd0;
      rsp_ready = 1'b0;
      reset_a = 1'b1;
      reset_b = 1'b1;

      // Reset state
      req_valid = 1'b1;
      @(posedge clock); @(posedge clock); #1;
      check("rst_req_ready", 32'(a_req_ready), 32'd0);
      check("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
      check("rst_rsp_rdata", a_rsp_rdata, 32'd0);
      check("rst_rsp_err", 32'(a_rsp_err), 32'd0);
      req_valid = 1'b0;
      reset_a = 1'b0;
      reset_b = 1'b0;
      #1;
      check("post_rst_req_ready", 32'(a_req_ready), 32'd1);
      @(posedge clock); #1;

      // Directed table
      for (int i = 0; i < NV; i++) begin
         txn(tv[i].w, tv[i].a, tv[i].f3, tv[i].wd, rd, er);
         model_op(tv[i].w, tv[i].a, tv[i].f3, tv[i].wd, mrd, mer);
         check($sformatf("vec%0d_rdata", i), rd, tv[i].exp_rd);
         check($sformatf("vec%0d_err", i), 32'(er), 32'(tv[i].exp_er));
      end

      // Backpressure: response held for 5 cycles while a second request waits
      req_write = 1'b0; req_addr = 32'h0100_0010; req_funct3 = 3'd2; req_valid = 1'b1;
      @(posedge clock); #1;
      req_addr = 32'h0100_0020;
      lat = 0;
      do begin
         @(posedge clock); #1;
         lat++;
      end while (!a_rsp_valid && lat < 50);
      check("bp_latency", 32'(lat), 32'd2);
      for (int c = 0; c < 5; c++) begin
         check("bp_rsp_valid", 32'(a_rsp_valid), 32'd1);
         check("bp_rsp_rdata", a_rsp_rdata, 32'hDEAD_BEEF);
         check("bp_rsp_err", 32'(a_rsp_err), 32'd0);
         check("bp_req_ready", 32'(a_req_ready), 32'd0);
         @(posedge clock); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
      check("bp_hs_rsp_valid", 32'(a_rsp_valid), 32'd0);
      check("bp_hs_req_ready", 32'(a_req_ready), 32'd1);
      @(posedge clock); #1;
      req_valid = 1'b0;
      check("bp_second_accept", 32'(a_req_ready), 32'd0);
      lat = 0;
      do begin
         @(posedge clock); #1;
         lat++;
      end while (!a_rsp_valid && lat < 50);
      check("bp2_latency", 32'(lat), 32'd2);
      check("bp2_rdata", a_rsp_rdata, 32'h80FF_7F01);
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;

      // Randomized traffic on a 16-word region, with aliased addresses
      for (int i = 0; i < 16; i++) begin
         logic [31:0] d;
         d = $urandom;
         txn(1'b1, 32'h0100_0100 + 32'(4*i), 3'd2, d, rd, er);
         model_op(1'b1, 32'h0100_0100 + 32'(4*i), 3'd2, d, mrd, mer);
         check("rinit_err", 32'(er), 32'(mer));
      end
      for (int i = 0; i < 150; i++) begin
         logic        w;
         logic [2:0]  f3;
         logic [31:0] a, d;
         int unsigned r;
         w = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 9);
         if (r >= 8) f3 = 3'($urandom_range(0, 7));
         else if (w) f3 = 3'($urandom_range(0, 2));
         else begin
            r = $urandom_range(0, 4);
            f3 = (r < 3) ? 3'(r) : 3'(r + 1);
         end
         a = 32'h0100_0100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3)) +
             32'(32'h1000 * $urandom_range(0, 3));
         d = $urandom;
         txn(w, a, f3, d, rd, er);
         model_op(w, a, f3, d, mrd, mer);
         check($sformatf("rnd%0d_rdata a=%08h f3=%0d w=%0d", i, a, f3, w), rd, mrd);
         check($sformatf("rnd%0d_err", i), 32'(er), 32'(mer));
      end

      // Reset during BUSY drops a store (instance B, LATENCY=4)
      sel = 1'b1;
      txn(1'b1, 32'h0100_0030, 3'd2, 32'hA5A5_A5A5, rd, er);
      req_write = 1'b1; req_addr = 32'h0100_0030; req_funct3 = 3'd2;
      req_wdata = 32'h1234_5678; req_valid = 1'b1;
      n = 0;
      while (!b_req_ready && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
      @(posedge clock); #2;
      reset_b = 1'b1;
      #1;
      check("rstbusy_rsp_valid", 32'(b_rsp_valid), 32'd0);
      check("rstbusy_req_ready", 32'(b_req_ready), 32'd0);
      @(posedge clock); @(posedge clock); #1;
      reset_b = 1'b0;
      @(posedge clock); #1;
      txn(1'b0, 32'h0100_0030, 3'd2, 32'h0, rd, er);
      check("rstbusy_old_value", rd, 32'hA5A5_A5A5);

      // Reset while a response is pending drops rsp_valid at once
      req_write = 1'b0; req_addr = 32'h0100_0030; req_funct3 = 3'd2; req_valid = 1'b1;
      @(posedge clock); #1;
      req_valid = 1'b0;
      lat = 0;
      do begin
         @(posedge clock); #1;
         lat++;
      end while (!b_rsp_valid && lat < 50);
      check("rstresp_pre_valid", 32'(b_rsp_valid), 32'd1);
      #2;
      reset_b = 1'b1;
      #1;
      check("rstresp_rsp_valid", 32'(b_rsp_valid), 32'd0);
      check("rstresp_rsp_rdata", b_rsp_rdata, 32'd0);
      @(posedge clock); #1;
      reset_b = 1'b0;
      @(posedge clock); #1;
      txn(1'b0, 32'h0100_0030 + 32'h1000, 3'd2, 32'h0, rd, er);
      check("alias_b_rdata", rd, 32'hA5A5_A5A5);
      check("alias_b_err", 32'(er), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
